llc_req_sched: RTL and testbench

- Parametrised front-end scheduler for the LLC pipeline; generalises the fixed four-source input decoder to NUM_CH channels.
- Each channel has a one-entry holding register, and a set-conflict stall mask blocks stalled channels.
- Channel 0 has strict priority (response path); channels 1..NUM_CH-1 are served round-robin.
- Issues one transaction at a time to the DECODE/LOOKUP/PROCESS/UPDATE pipeline and waits for its done pulse before the next grant.

---
 rtl/llc_req_sched_pkg.sv | 30 +++
 rtl/llc_req_sched_rr_pick.sv | 30 +++
 rtl/llc_req_sched.sv | 146 ++++++++++++++
 tb/tb_llc_req_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_req_sched_pkg.sv
// Shared LLC scheduler package: FSM state type, set-index helper and default widths
// derived from the cache geometry constants.
package llc_req_sched_pkg;

    localparam int LLC_ADDR_W   = 32;
    localparam int LLC_OFFSET_W = 4;
    localparam int LLC_SET_W    = 8;

    localparam int SCHED_DEF_NUM_CH   = 4;
    localparam int SCHED_DEF_ADDR_W   = LLC_ADDR_W;
    localparam int SCHED_DEF_DATA_W   = 64;
    localparam int SCHED_DEF_OFFSET_W = LLC_OFFSET_W;
    localparam int SCHED_DEF_SET_W    = LLC_SET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } sched_state_t;

    // Address is zero-extended to 64 bits by the caller; set widths below 32 are supported.
    function automatic logic [31:0] set_of(input logic [63:0] addr,
                                           input int unsigned offset_w,
                                           input int unsigned set_w);
        logic [63:0] sh;
        sh = addr >> offset_w;
        return sh[31:0] & ((32'h1 << set_w) - 32'h1);
    endfunction

endpackage

// File: rtl/llc_req_sched_rr_pick.sv
// Combinational round-robin picker over channels 1..NUM_CH-1, starting the
// search at ptr and wrapping back to 1; channel 0 is never selected here.
module llc_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    always_comb begin
        int c;
        logic [IDX_W-1:0] cidx;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cidx  = '0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            c    = 1 + ((int'(ptr) - 1 + k) % (NUM_CH - 1));
            cidx = IDX_W'(c);
            if (!found && c >= 1 && mask[cidx]) begin
                found = 1'b1;
                idx   = cidx;
            end
        end
    end

endmodule

// File: rtl/llc_req_sched.sv
// LLC front-end request scheduler: per-channel holding slots, set-conflict masking,
// channel 0 strict priority, round-robin on the rest. Optional LLC_SCHED_STATS_EN adds counters.
module llc_req_sched
    import llc_req_sched_pkg::*;
#(
    parameter int NUM_CH   = SCHED_DEF_NUM_CH,
    parameter int ADDR_W   = SCHED_DEF_ADDR_W,
    parameter int DATA_W   = SCHED_DEF_DATA_W,
    parameter int OFFSET_W = SCHED_DEF_OFFSET_W,
    parameter int SET_W    = SCHED_DEF_SET_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   in_addr,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic                       blk_valid,
    input  logic [SET_W-1:0]           blk_set,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       done,
`ifdef LLC_SCHED_STATS_EN
    output logic [31:0]                stall_cycles,
    output logic [NUM_CH*16-1:0]       grants,
`endif
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    sched_state_t      state, state_nx;
    logic [NUM_CH-1:0] held, elig, cap;
    logic [ADDR_W-1:0] addr_q [NUM_CH];
    logic [DATA_W-1:0] data_q [NUM_CH];
    logic [IDX_W-1:0]  rr_ptr, rr_idx, gnt_idx;
    logic              rr_found, gnt_any, grant, hs;

    assign in_ready = ~held;
    assign cap      = in_valid & ~held;

    always_comb begin
        logic [63:0] a64;
        a64  = '0;
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            a64 = '0;
            a64[ADDR_W-1:0] = addr_q[i];
            elig[i] = held[i] &&
                      !(blk_valid && set_of(a64, OFFSET_W, SET_W) == 32'(blk_set));
        end
    end

    llc_rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr_pick (
        .mask  (elig),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

    assign gnt_any = elig[0] | rr_found;
    assign gnt_idx = elig[0] ? '0 : rr_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any)               state_nx = ISSUE;
            ISSUE:   if (out_valid && out_ready) state_nx = BUSY;
            BUSY:    if (done)                  state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant = (state == IDLE) && gnt_any;
        hs    = (state == ISSUE) && out_valid && out_ready;
        busy  = (state != IDLE);
    end

    // Payload slots carry no reset; held[] alone qualifies them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
                addr_q[i] <= in_addr[i*ADDR_W +: ADDR_W];
                data_q[i] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            rr_ptr    <= IDX_W'(1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap[i]) held[i] <= 1'b1;
            end
            if (grant) begin
                out_valid <= 1'b1;
                out_ch    <= gnt_idx;
                out_addr  <= addr_q[gnt_idx];
                out_data  <= data_q[gnt_idx];
            end
            if (hs) begin
                held[out_ch] <= 1'b0;
                out_valid    <= 1'b0;
                if (out_ch != '0)
                    rr_ptr <= (out_ch == IDX_W'(NUM_CH - 1)) ? IDX_W'(1) : out_ch + 1'b1;
            end
        end
    end

`ifdef LLC_SCHED_STATS_EN
    logic [15:0] gcnt [NUM_CH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            for (int i = 0; i < NUM_CH; i++) gcnt[i] <= '0;
        end else begin
            if (state == IDLE && held != '0 && elig == '0 && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (hs)
                gcnt[out_ch] <= gcnt[out_ch] + 16'd1;
        end
    end

    always_comb begin
        grants = '0;
        for (int i = 0; i < NUM_CH; i++) grants[i*16 +: 16] = gcnt[i];
    end
`endif

endmodule

// File: tb/tb_llc_req_sched.sv
// Directed-vector bench for llc_req_sched (NUM_CH=4); expected values are hand-derived.
module tb_llc_req_sched;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int SET_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*ADDR_W-1:0] in_addr = '0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic                     blk_valid = 1'b0;
    logic [SET_W-1:0]         blk_set = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [1:0]               out_ch;
    logic [ADDR_W-1:0]        out_addr;
    logic [DATA_W-1:0]        out_data;
    logic                     done = 1'b0;
    logic                     busy;
`ifdef LLC_SCHED_STATS_EN
    logic [31:0]              stall_cycles;
    logic [NUM_CH*16-1:0]     grants;
`endif

    int vectors     = 0;
    int miscompares = 0;

    llc_req_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .OFFSET_W(4), .SET_W(SET_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .blk_valid (blk_valid),
        .blk_set   (blk_set),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .done      (done),
`ifdef LLC_SCHED_STATS_EN
        .stall_cycles (stall_cycles),
        .grants       (grants),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = '0; done = 1'b0; out_ready = 1'b1; blk_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic load(input int ch, input logic [31:0] a, input logic [63:0] d);
        in_valid[ch] = 1'b1;
        in_addr[ch*ADDR_W +: ADDR_W] = a;
        in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    // Expects a grant to exp_ch, completes the handshake and returns the FSM to IDLE.
    task automatic serve(input string tag, input int exp_ch);
        wait_valid(tag);
        check(tag, 64'(out_ch), 64'(exp_ch));
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        do_reset();
        check("rst_in_ready", 64'(in_ready), 64'hf);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
`ifdef LLC_SCHED_STATS_EN
        check("rst_stall", 64'(stall_cycles), 64'd0);
        check("rst_grants", grants, 64'd0);
`endif

        // single request on ch2
        load(2, 32'h0000_1230, 64'h0000_0000_0000_0abc);
        tick();
        in_valid = '0;
        check("single_ready_held", 64'(in_ready), 64'hb);
        check("single_nolat", 64'(out_valid), 64'd0);
        tick();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_ch", 64'(out_ch), 64'd2);
        check("single_addr", 64'(out_addr), 64'h1230);
        check("single_data", out_data, 64'habc);
        check("single_ready_issue", 64'(in_ready), 64'hb);
        tick();
        check("single_valid_drop", 64'(out_valid), 64'd0);
        check("single_busy", 64'(busy), 64'd1);
        check("single_ready_free", 64'(in_ready), 64'hf);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("single_idle", 64'(busy), 64'd0);

        // priority: ch0 wins, then round-robin; ch0 refilled after the first grant
        do_reset();
        load(0, 32'h100, 64'h10);
        load(1, 32'h200, 64'h11);
        load(3, 32'h300, 64'h13);
        tick();
        in_valid = '0;
        serve("pri_g0", 0);
        load(0, 32'h400, 64'h20);
        tick();
        in_valid = '0;
        serve("pri_g1", 1);
        serve("pri_g2", 0);
        serve("pri_g3", 3);
        check("pri_all_free", 64'(in_ready), 64'hf);

        // round-robin fairness with ch1..ch3 continuously valid
        do_reset();
        load(1, 32'h1000, 64'h1);
        load(2, 32'h2000, 64'h2);
        load(3, 32'h3000, 64'h3);
        tick();
        serve("rr_1a", 1);
        serve("rr_2a", 2);
        serve("rr_3a", 3);
        serve("rr_1b", 1);
        serve("rr_2b", 2);
        serve("rr_3b", 3);
        in_valid = '0;

        // set block: ch1 at set 0x23 blocked, ch2 at set 0x24 proceeds
        do_reset();
        blk_valid = 1'b1;
        blk_set   = 8'h23;
        load(1, 32'h0000_0230, 64'haa);
        load(2, 32'h0000_0240, 64'hbb);
        tick();
        in_valid = '0;
        serve("blk_first", 2);
        repeat (3) tick();
        check("blk_no_issue", 64'(out_valid), 64'd0);
        check("blk_idle", 64'(busy), 64'd0);
        check("blk_ch1_held", 64'(in_ready), 64'hd);
`ifdef LLC_SCHED_STATS_EN
        check("blk_stall", 64'(stall_cycles), 64'd3);
`endif
        blk_valid = 1'b0;
        serve("blk_release", 1);
        check("blk_release_addr", 64'(out_addr), 64'h230);
`ifdef LLC_SCHED_STATS_EN
        check("blk_grants", grants, 64'h0000_0001_0001_0000);
`endif

        // backpressure with a stray done while in ISSUE
        do_reset();
        out_ready = 1'b0;
        load(1, 32'hdead_bee0, 64'h1122_3344_5566_7788);
        tick();
        in_valid = '0;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ch", 64'(out_ch), 64'd1);
            check("bp_addr", 64'(out_addr), 64'hdead_bee0);
            check("bp_data", out_data, 64'h1122_3344_5566_7788);
            done = (i == 2);
            tick();
            done = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs_drop", 64'(out_valid), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        repeat (3) tick();
        check("bp_wait_done", 64'(busy), 64'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("bp_idle", 64'(busy), 64'd0);

        // reset while BUSY with three channels held
        do_reset();
        load(2, 32'h500, 64'h55);
        tick();
        in_valid = '0;
        wait_valid("mid");
        tick();
        load(0, 32'h600, 64'h60);
        load(1, 32'h700, 64'h61);
        load(3, 32'h800, 64'h63);
        tick();
        in_valid = '0;
        check("mid_held", 64'(in_ready), 64'h4);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'(in_ready), 64'hf);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
`ifdef LLC_SCHED_STATS_EN
        check("mid_rst_stall", 64'(stall_cycles), 64'd0);
        check("mid_rst_grants", grants, 64'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        load(1, 32'h900, 64'h71);
        load(3, 32'ha00, 64'h73);
        tick();
        in_valid = '0;
        serve("mid_rr_ptr", 1);
        serve("mid_next", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
